// File: rtl/cv32e41s_pmp_arbiter_pkg.sv
// Shared types for the PMP/PMR checker arbiter between IF and LSU.
// Optional round-robin arbitration is enabled with CV32E41S_PMP_ARB_RR_EN.
package cv32e41s_pmp_arbiter_pkg;

  localparam int unsigned ADDR_W = 34;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    PMP_ACC_EXEC  = 2'b00,
    PMP_ACC_WRITE = 2'b01,
    PMP_ACC_READ  = 2'b10
  } pmp_req_e;

  typedef enum logic {
    ARB_SRC_IF  = 1'b0,
    ARB_SRC_LSU = 1'b1
  } pmp_arb_src_e;

  typedef enum logic {
    ARB_IDLE    = 1'b0,
    ARB_QUIESCE = 1'b1
  } pmp_arb_state_e;

  typedef struct packed {
    logic              valid;
    pmp_arb_src_e      src;
    logic [ADDR_W-1:0] addr;
    pmp_req_e          req_type;
    logic              dbg;
  } pmp_arb_stage_t;

  // LSU access type from the write-enable bit
  function automatic pmp_req_e lsu_req_type(input logic we);
    return we ? PMP_ACC_WRITE : PMP_ACC_READ;
  endfunction

endpackage

// File: rtl/cv32e41s_pmp_arbiter_if.sv
// Requester-side handshake bundle (IF and LSU request/response channels).
// Used unchanged whether or not CV32E41S_PMP_ARB_RR_EN is defined.
interface cv32e41s_pmp_arbiter_if;
  import cv32e41s_pmp_arbiter_pkg::*;

  logic              if_req_valid_i;
  logic              if_req_ready_o;
  logic [ADDR_W-1:0] if_req_addr_i;
  logic              if_req_debug_region_i;

  logic              lsu_req_valid_i;
  logic              lsu_req_ready_o;
  logic [ADDR_W-1:0] lsu_req_addr_i;
  logic              lsu_req_we_i;
  logic              lsu_req_debug_region_i;

  logic              if_resp_valid_o;
  logic              if_resp_ready_i;
  logic              if_resp_err_o;
  logic [ADDR_W-1:0] if_resp_addr_o;

  logic              lsu_resp_valid_o;
  logic              lsu_resp_ready_i;
  logic              lsu_resp_err_o;
  logic [ADDR_W-1:0] lsu_resp_addr_o;

  modport master (
    output if_req_valid_i, if_req_addr_i, if_req_debug_region_i,
    output lsu_req_valid_i, lsu_req_addr_i, lsu_req_we_i, lsu_req_debug_region_i,
    output if_resp_ready_i, lsu_resp_ready_i,
    input  if_req_ready_o, lsu_req_ready_o,
    input  if_resp_valid_o, if_resp_err_o, if_resp_addr_o,
    input  lsu_resp_valid_o, lsu_resp_err_o, lsu_resp_addr_o
  );

  modport slave (
    input  if_req_valid_i, if_req_addr_i, if_req_debug_region_i,
    input  lsu_req_valid_i, lsu_req_addr_i, lsu_req_we_i, lsu_req_debug_region_i,
    input  if_resp_ready_i, lsu_resp_ready_i,
    output if_req_ready_o, lsu_req_ready_o,
    output if_resp_valid_o, if_resp_err_o, if_resp_addr_o,
    output lsu_resp_valid_o, lsu_resp_err_o, lsu_resp_addr_o
  );

endinterface

// File: rtl/cv32e41s_pmp_arb_sel.sv
// Combinational winner selection for the PMP checker stage.
// CV32E41S_PMP_ARB_RR_EN selects round-robin instead of LSU priority with starvation guard.
module cv32e41s_pmp_arb_sel
  import cv32e41s_pmp_arbiter_pkg::*;
`ifndef CV32E41S_PMP_ARB_RR_EN
#(
  parameter int unsigned STARVE_LIMIT = 4
)
`endif
(
  input  logic             if_valid,
  input  logic             lsu_valid,
  input  logic             gnt_possible,
`ifdef CV32E41S_PMP_ARB_RR_EN
  input  pmp_arb_src_e     last_src,
`else
  input  logic [CNT_W-1:0] starve_cnt,
`endif
  output logic             if_gnt_c,
  output logic             lsu_gnt_c
);

  logic if_wins;

`ifdef CV32E41S_PMP_ARB_RR_EN
  // On contention the requester that did not win last time goes first
  assign if_wins = if_valid & (~lsu_valid | (last_src == ARB_SRC_LSU));
`else
  // LSU first unless IF has been refused STARVE_LIMIT times in a row
  assign if_wins = if_valid & (~lsu_valid | (starve_cnt == CNT_W'(STARVE_LIMIT)));
`endif

  assign if_gnt_c  = gnt_possible & if_wins;
  assign lsu_gnt_c = gnt_possible & lsu_valid & ~if_wins;

endmodule

// File: rtl/cv32e41s_pmp_arbiter.sv
// Shares one PMP/PMR checker between IF and LSU through a single stage register,
// holding off grants and responses around PMP CSR writes. Option: CV32E41S_PMP_ARB_RR_EN.
module cv32e41s_pmp_arbiter
  import cv32e41s_pmp_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
)
(
  input  logic                 clk,
  input  logic                 rst_n,
  cv32e41s_pmp_arbiter_if.slave bus,
  output logic [ADDR_W-1:0]    chk_req_addr_o,
  output pmp_req_e             chk_req_type_o,
  output logic                 chk_req_debug_region_o,
  input  logic                 chk_err_i,
  input  logic [ADDR_W-1:0]    chk_reloc_addr_i,
  input  logic                 csr_pmp_wr_i
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_QUIESCE = 1'b1;

  logic [0:0]     state_q, state_d;
  pmp_arb_stage_t stage_q, stage_d;

  logic resp_hold_c;
  logic if_resp_vld_c;
  logic lsu_resp_vld_c;
  logic delivered_c;
  logic stage_free_c;
  logic gnt_possible_c;
  logic if_gnt_c;
  logic lsu_gnt_c;

  // Responses are withheld while the PMP configuration is in flux
  assign resp_hold_c    = (state_q == ST_QUIESCE) | csr_pmp_wr_i;
  assign if_resp_vld_c  = stage_q.valid & (stage_q.src == ARB_SRC_IF)  & ~resp_hold_c;
  assign lsu_resp_vld_c = stage_q.valid & (stage_q.src == ARB_SRC_LSU) & ~resp_hold_c;
  assign delivered_c    = (if_resp_vld_c  & bus.if_resp_ready_i) |
                          (lsu_resp_vld_c & bus.lsu_resp_ready_i);
  assign stage_free_c   = ~stage_q.valid | delivered_c;
  assign gnt_possible_c = rst_n & stage_free_c & (state_q == ST_IDLE) & ~csr_pmp_wr_i;

`ifdef CV32E41S_PMP_ARB_RR_EN
  pmp_arb_src_e last_src_q, last_src_d;

  cv32e41s_pmp_arb_sel u_sel (
    .if_valid     (bus.if_req_valid_i),
    .lsu_valid    (bus.lsu_req_valid_i),
    .gnt_possible (gnt_possible_c),
    .last_src     (last_src_q),
    .if_gnt_c     (if_gnt_c),
    .lsu_gnt_c    (lsu_gnt_c)
  );

  always_comb begin
    last_src_d = last_src_q;
    if (if_gnt_c) begin
      last_src_d = ARB_SRC_IF;
    end else if (lsu_gnt_c) begin
      last_src_d = ARB_SRC_LSU;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_src_q <= ARB_SRC_LSU;
    end else begin
      last_src_q <= last_src_d;
    end
  end
`else
  logic [CNT_W-1:0] starve_q, starve_d;

  cv32e41s_pmp_arb_sel #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_sel (
    .if_valid     (bus.if_req_valid_i),
    .lsu_valid    (bus.lsu_req_valid_i),
    .gnt_possible (gnt_possible_c),
    .starve_cnt   (starve_q),
    .if_gnt_c     (if_gnt_c),
    .lsu_gnt_c    (lsu_gnt_c)
  );

  // Count consecutive refusals of a waiting IF request; frozen while nothing can be granted
  always_comb begin
    starve_d = starve_q;
    if (!bus.if_req_valid_i || if_gnt_c) begin
      starve_d = '0;
    end else if (lsu_gnt_c && (starve_q != CNT_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`endif

  // Quiesce FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (csr_pmp_wr_i) state_d = ST_QUIESCE;
      ST_QUIESCE: if (!csr_pmp_wr_i) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Stage load on grant, cleared to all-zero when its response is taken
  always_comb begin
    stage_d = stage_q;
    if (if_gnt_c) begin
      stage_d.valid    = 1'b1;
      stage_d.src      = ARB_SRC_IF;
      stage_d.addr     = bus.if_req_addr_i;
      stage_d.req_type = PMP_ACC_EXEC;
      stage_d.dbg      = bus.if_req_debug_region_i;
    end else if (lsu_gnt_c) begin
      stage_d.valid    = 1'b1;
      stage_d.src      = ARB_SRC_LSU;
      stage_d.addr     = bus.lsu_req_addr_i;
      stage_d.req_type = lsu_req_type(bus.lsu_req_we_i);
      stage_d.dbg      = bus.lsu_req_debug_region_i;
    end else if (delivered_c) begin
      stage_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  // The stage is kept all-zero while empty, so the checker sees 0 then
  assign chk_req_addr_o         = stage_q.addr;
  assign chk_req_type_o         = stage_q.req_type;
  assign chk_req_debug_region_o = stage_q.dbg;

  assign bus.if_req_ready_o   = if_gnt_c;
  assign bus.lsu_req_ready_o  = lsu_gnt_c;

  assign bus.if_resp_valid_o  = if_resp_vld_c;
  assign bus.if_resp_err_o    = if_resp_vld_c & chk_err_i;
  assign bus.if_resp_addr_o   = if_resp_vld_c ? chk_reloc_addr_i : '0;

  assign bus.lsu_resp_valid_o = lsu_resp_vld_c;
  assign bus.lsu_resp_err_o   = lsu_resp_vld_c & chk_err_i;
  assign bus.lsu_resp_addr_o  = lsu_resp_vld_c ? chk_reloc_addr_i : '0;

endmodule

// File: tb/tb_cv32e41s_pmp_arbiter.sv
// Directed self-checking bench for cv32e41s_pmp_arbiter (both arbitration builds).
module tb_cv32e41s_pmp_arbiter;
  import cv32e41s_pmp_arbiter_pkg::*;

  localparam int unsigned STARVE_LIMIT = 4;
  localparam logic [33:0] RELOC_XOR   = 34'h3_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [33:0] chk_req_addr;
  pmp_req_e    chk_req_type;
  logic        chk_req_dbg;
  logic        chk_err;
  logic [33:0] chk_reloc;
  logic        csr_pmp_wr;

  int n_checks = 0;
  int n_errors = 0;

  cv32e41s_pmp_arbiter_if bus();

  cv32e41s_pmp_arbiter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .bus                    (bus),
    .chk_req_addr_o         (chk_req_addr),
    .chk_req_type_o         (chk_req_type),
    .chk_req_debug_region_o (chk_req_dbg),
    .chk_err_i              (chk_err),
    .chk_reloc_addr_i       (chk_reloc),
    .csr_pmp_wr_i           (csr_pmp_wr)
  );

  always #5 clk = ~clk;

  // Checker stand-in: relocation is a fixed XOR of the staged address
  assign chk_reloc = chk_req_addr ^ RELOC_XOR;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  function automatic logic exp_if_win(input int k);
`ifdef CV32E41S_PMP_ARB_RR_EN
    return (k % 2) == 0;
`else
    return (k % 5) == 4;
`endif
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n                      = 1'b0;
    csr_pmp_wr                 = 1'b0;
    chk_err                    = 1'b0;
    bus.if_req_valid_i         = 1'b0;
    bus.if_req_addr_i          = '0;
    bus.if_req_debug_region_i  = 1'b0;
    bus.lsu_req_valid_i        = 1'b1;
    bus.lsu_req_addr_i         = 34'h0_0000_1000;
    bus.lsu_req_we_i           = 1'b0;
    bus.lsu_req_debug_region_i = 1'b0;
    bus.if_resp_ready_i        = 1'b1;
    bus.lsu_resp_ready_i       = 1'b1;

    // Reset: everything quiet even with a pending LSU request
    settle();
    check("rst_lsu_ready", 64'(bus.lsu_req_ready_o), 64'd0);
    check("rst_if_ready", 64'(bus.if_req_ready_o), 64'd0);
    check("rst_lsu_resp", 64'(bus.lsu_resp_valid_o), 64'd0);
    check("rst_chk_addr", 64'(chk_req_addr), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Single LSU read, one-cycle latency, back-to-back accept
    settle();
    check("t1_lsu_ready", 64'(bus.lsu_req_ready_o), 64'd1);
    check("t1_if_ready", 64'(bus.if_req_ready_o), 64'd0);
    check("t1_resp_early", 64'(bus.lsu_resp_valid_o), 64'd0);
    tick();
    bus.lsu_req_addr_i = 34'h0_0000_2000;
    bus.lsu_req_we_i   = 1'b1;
    settle();
    check("t1_resp_valid", 64'(bus.lsu_resp_valid_o), 64'd1);
    check("t1_chk_type", 64'(chk_req_type), 64'(PMP_ACC_READ));
    check("t1_chk_addr", 64'(chk_req_addr), 64'h0_0000_1000);
    check("t1_resp_addr", 64'(bus.lsu_resp_addr_o), 64'h3_0000_1000);
    check("t1_resp_err", 64'(bus.lsu_resp_err_o), 64'd0);
    check("t1_next_accept", 64'(bus.lsu_req_ready_o), 64'd1);
    tick();
    bus.lsu_req_valid_i = 1'b0;
    settle();
    check("t1_chk_type_wr", 64'(chk_req_type), 64'(PMP_ACC_WRITE));
    check("t1_resp2_valid", 64'(bus.lsu_resp_valid_o), 64'd1);
    tick();
    settle();
    check("t1_drained", 64'(bus.lsu_resp_valid_o), 64'd0);
    check("t1_chk_idle", 64'(chk_req_addr), 64'd0);
    check("t1_addr_idle", 64'(bus.lsu_resp_addr_o), 64'd0);

    // Contention: arbitration pattern over 10 cycles
    bus.if_req_valid_i  = 1'b1;
    bus.if_req_addr_i   = 34'h0_0000_0100;
    bus.lsu_req_valid_i = 1'b1;
    bus.lsu_req_addr_i  = 34'h0_0000_0200;
    bus.lsu_req_we_i    = 1'b0;
    for (int k = 0; k < 10; k++) begin
      settle();
      check("t2_if_gnt", 64'(bus.if_req_ready_o), 64'(exp_if_win(k)));
      check("t2_lsu_gnt", 64'(bus.lsu_req_ready_o), 64'(!exp_if_win(k)));
      if (k > 0) begin
        check("t2_if_resp", 64'(bus.if_resp_valid_o), 64'(exp_if_win(k - 1)));
        check("t2_lsu_resp", 64'(bus.lsu_resp_valid_o), 64'(!exp_if_win(k - 1)));
      end
      tick();
    end
    bus.if_req_valid_i  = 1'b0;
    bus.lsu_req_valid_i = 1'b0;
    tick();

    // LSU response back-pressured for 3 cycles while IF waits
    bus.lsu_req_valid_i  = 1'b1;
    bus.lsu_req_addr_i   = 34'h0_0000_3000;
    bus.lsu_req_we_i     = 1'b1;
    bus.lsu_resp_ready_i = 1'b0;
    settle();
    check("t3_lsu_ready", 64'(bus.lsu_req_ready_o), 64'd1);
    tick();
    bus.lsu_req_valid_i = 1'b0;
    bus.if_req_valid_i  = 1'b1;
    bus.if_req_addr_i   = 34'h0_0000_4000;
    for (int k = 0; k < 3; k++) begin
      settle();
      check("t3_hold_valid", 64'(bus.lsu_resp_valid_o), 64'd1);
      check("t3_hold_addr", 64'(bus.lsu_resp_addr_o), 64'h3_0000_3000);
      check("t3_if_blocked", 64'(bus.if_req_ready_o), 64'd0);
      check("t3_lsu_blocked", 64'(bus.lsu_req_ready_o), 64'd0);
      tick();
    end
    bus.lsu_resp_ready_i = 1'b1;
    settle();
    check("t3_take_valid", 64'(bus.lsu_resp_valid_o), 64'd1);
    check("t3_if_gnt", 64'(bus.if_req_ready_o), 64'd1);
    tick();
    bus.if_req_valid_i = 1'b0;
    settle();
    check("t3_if_resp", 64'(bus.if_resp_valid_o), 64'd1);
    check("t3_chk_exec", 64'(chk_req_type), 64'(PMP_ACC_EXEC));
    check("t3_chk_addr", 64'(chk_req_addr), 64'h0_0000_4000);
    tick();

    // CSR write while an IF check is staged; check result flips on the new config
    bus.if_req_valid_i        = 1'b1;
    bus.if_req_addr_i         = 34'h0_0000_5000;
    bus.if_req_debug_region_i = 1'b1;
    bus.if_resp_ready_i       = 1'b0;
    settle();
    check("t4_if_gnt", 64'(bus.if_req_ready_o), 64'd1);
    tick();
    bus.if_req_valid_i  = 1'b0;
    bus.lsu_req_valid_i = 1'b1;
    bus.lsu_req_addr_i  = 34'h0_0000_6000;
    bus.lsu_req_we_i    = 1'b0;
    settle();
    check("t4_pre_valid", 64'(bus.if_resp_valid_o), 64'd1);
    check("t4_pre_err", 64'(bus.if_resp_err_o), 64'd0);
    check("t4_chk_dbg", 64'(chk_req_dbg), 64'd1);
    check("t4_pre_busy", 64'(bus.lsu_req_ready_o), 64'd0);
    tick();
    csr_pmp_wr          = 1'b1;
    chk_err             = 1'b1;
    bus.if_resp_ready_i = 1'b1;
    settle();
    check("t4_wr_valid", 64'(bus.if_resp_valid_o), 64'd0);
    check("t4_wr_err", 64'(bus.if_resp_err_o), 64'd0);
    check("t4_wr_gnt", 64'(bus.lsu_req_ready_o), 64'd0);
    tick();
    csr_pmp_wr = 1'b0;
    settle();
    check("t4_q_valid", 64'(bus.if_resp_valid_o), 64'd0);
    check("t4_q_gnt", 64'(bus.lsu_req_ready_o), 64'd0);
    tick();
    settle();
    check("t4_post_valid", 64'(bus.if_resp_valid_o), 64'd1);
    check("t4_post_err", 64'(bus.if_resp_err_o), 64'd1);
    check("t4_post_addr", 64'(bus.if_resp_addr_o), 64'h3_0000_5000);
    check("t4_post_gnt", 64'(bus.lsu_req_ready_o), 64'd1);
    tick();
    bus.lsu_req_valid_i = 1'b0;
    chk_err             = 1'b0;
    settle();
    check("t4_lsu_resp", 64'(bus.lsu_resp_valid_o), 64'd1);
    tick();

    // Three back-to-back CSR writes stretch the quiesce window
    bus.lsu_req_valid_i = 1'b1;
    csr_pmp_wr          = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      check("t5_wr_gnt", 64'(bus.lsu_req_ready_o), 64'd0);
      tick();
    end
    csr_pmp_wr = 1'b0;
    settle();
    check("t5_q_gnt", 64'(bus.lsu_req_ready_o), 64'd0);
    tick();
    settle();
    check("t5_resume_gnt", 64'(bus.lsu_req_ready_o), 64'd1);
    tick();
    bus.lsu_req_valid_i = 1'b0;
    settle();
    check("t5_resp", 64'(bus.lsu_resp_valid_o), 64'd1);
    tick();

    // Reset with a staged request and a non-zero starve count
    bus.if_req_valid_i  = 1'b1;
    bus.lsu_req_valid_i = 1'b1;
    tick();
    bus.if_resp_ready_i  = 1'b0;
    bus.lsu_resp_ready_i = 1'b0;
    settle();
    rst_n = 1'b0;
    #1;
    check("t6_if_resp", 64'(bus.if_resp_valid_o), 64'd0);
    check("t6_lsu_resp", 64'(bus.lsu_resp_valid_o), 64'd0);
    check("t6_if_ready", 64'(bus.if_req_ready_o), 64'd0);
    check("t6_lsu_ready", 64'(bus.lsu_req_ready_o), 64'd0);
    check("t6_chk_addr", 64'(chk_req_addr), 64'd0);
    tick();
    tick();
    rst_n                = 1'b1;
    bus.if_resp_ready_i  = 1'b1;
    bus.lsu_resp_ready_i = 1'b1;
    settle();
    check("t6_no_if_resp", 64'(bus.if_resp_valid_o), 64'd0);
    check("t6_no_lsu_resp", 64'(bus.lsu_resp_valid_o), 64'd0);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) settle();
      check("t6_if_gnt", 64'(bus.if_req_ready_o), 64'(exp_if_win(k)));
      check("t6_lsu_gnt", 64'(bus.lsu_req_ready_o), 64'(!exp_if_win(k)));
      tick();
    end
    bus.if_req_valid_i  = 1'b0;
    bus.lsu_req_valid_i = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
